// File: rtl/bin_to_bcd.sv
// bin_to_bcd: sequential binary-to-packed-BCD converter (shift-and-add-3),
// one input bit per clock, start/busy/done handshake.
// Optional build macro BIN_TO_BCD_SATURATE_EN: values above 10^DIGITS-1
// produce all-nines with ovf=1 instead of wrapping modulo 10^DIGITS.
module bin_to_bcd #(
   parameter int BIN_W  = 17,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  busy,
   output logic                  done,
   output logic                  ovf
);

   localparam int ACC_W = 4 * DIGITS;
   localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t             state;
   logic [BIN_W-1:0]   sh;
   logic [ACC_W-1:0]   acc;
   logic [CNT_W-1:0]   cnt;
   logic [ACC_W-1:0]   acc_adj;
   logic [ACC_W-1:0]   acc_next;
   logic [BIN_W-1:0]   sh_next;
   logic               sat;

   // Every digit >= 5 gets +3 so that the following doubling carries
   // correctly into the next decimal digit.
   function automatic logic [ACC_W-1:0] add3(input logic [ACC_W-1:0] a);
      logic [ACC_W-1:0] r;
      r = a;
      for (int i = 0; i < DIGITS; i++) begin
         if (a[4*i +: 4] >= 4'd5)
            r[4*i +: 4] = a[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

`ifdef BIN_TO_BCD_SATURATE_EN
   // Largest value representable in DIGITS decimal digits.
   function automatic logic [63:0] max_dec(input int d);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < d; i++)
         p = p * 64'd10;
      return p - 64'd1;
   endfunction

   localparam logic [63:0] MAX_VAL = max_dec(DIGITS);
`endif

   // Digit correction then one-bit left shift of {acc, sh}; top bit of acc is dropped.
   always_comb begin
      acc_adj             = add3(acc);
      {acc_next, sh_next} = {acc_adj, sh} << 1;
   end

   // Datapath registers: operand capture on accept, shift while converting.
   always_ff @(posedge clk) begin
      if (state == IDLE) begin
         if (start) begin
            sh  <= bin;
            acc <= '0;
`ifdef BIN_TO_BCD_SATURATE_EN
            sat <= ({{(64-BIN_W){1'b0}}, bin} > MAX_VAL);
`else
            sat <= 1'b0;
`endif
         end
      end else begin
         sh  <= sh_next;
         acc <= acc_next;
      end
   end

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         ovf   <= 1'b0;
         bcd   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= SHIFT;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            SHIFT: begin
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_LAST) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
`ifdef BIN_TO_BCD_SATURATE_EN
                  bcd   <= sat ? {DIGITS{4'h9}} : acc_next;
                  ovf   <= sat;
`else
                  bcd   <= acc_next;
                  ovf   <= sat;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
